uart_rom_loader: RTL and testbench
==================================

UART_ROM_LOADER -- requirements
Module: uart_rom_loader

Interface
REQ-001 Parameter ADDR_W, default 18, is the ROM image address width (262144 bytes).
REQ-002 Parameter SYNC_BYTE, default 8'hA5, is the frame start marker.
REQ-003 Parameter TIMEOUT_CYC, default 4000000, is the maximum number of idle clk_4 cycles between bytes inside a frame (1 s).
REQ-004 clk_4  input  1  system clock; all logic is on the rising edge.
REQ-005 vb_rst  input  1  asynchronous, active-high reset.
REQ-006 rx_rdy  input  1  UART byte-available level, held high until cleared.
REQ-007 rx_data  input  8  UART received byte, valid while rx_rdy=1.
REQ-008 rx_rdy_clr  output  1  one-cycle pulse that consumes the current byte.
REQ-009 vb_rom_a  input  ADDR_W  Game Boy core ROM address.
REQ-010 mem_a  output  ADDR_W  ROM RAM address.
REQ-011 mem_d  output  8  ROM RAM write data.
REQ-012 mem_we  output  1  ROM RAM write enable.
REQ-013 hold_rst  output  1  holds the Game Boy core in reset; ORed into the core reset externally.
REQ-014 busy  output  1  high while a frame is in progress.
REQ-015 done  output  1  sticky flag: last frame loaded with a good checksum.
REQ-016 err  output  1  sticky flag: last frame failed.
REQ-017 byte_cnt  output  ADDR_W+1  count of payload bytes written in the current or last frame.

Function
REQ-018 A byte is accepted in any cycle where rx_rdy=1, unless rx_rdy_clr was high in the previous cycle; rx_rdy_clr is asserted in the same cycle as the acceptance.
REQ-019 Frame format: SYNC_BYTE; LEN[23:16], LEN[15:8], LEN[7:0]; LEN payload bytes; one checksum byte equal to the 8-bit modulo-256 sum of the payload.
REQ-020 States: IDLE, LEN0, LEN1, LEN2, DATA, CSUM, DONE, ERR.
REQ-021 IDLE or ERR, accepted byte == SYNC_BYTE -> LEN0; in the same cycle clear done, err, byte_cnt, the checksum accumulator and the write pointer.
REQ-022 IDLE or ERR, accepted byte != SYNC_BYTE -> the byte is consumed and discarded; the state is unchanged.
REQ-023 LEN0 -> LEN1 -> LEN2 -> DATA, each step on one accepted byte.
REQ-024 On leaving LEN2, if LEN == 0 or LEN > 2^ADDR_W, the next state is ERR instead of DATA.
REQ-025 DATA, per accepted byte: in the next cycle mem_we=1, mem_a=pointer, mem_d=byte; the pointer and byte_cnt increment after that write; the checksum adds the byte modulo 256.
REQ-026 DATA -> CSUM when the byte with index LEN-1 is accepted.
REQ-027 CSUM, accepted byte == accumulator -> DONE; otherwise -> ERR.
REQ-028 DONE lasts one cycle: it sets done=1, then moves to IDLE.
REQ-029 Entry to ERR sets err=1.
REQ-030 hold_rst=1 in LEN0, LEN1, LEN2, DATA, CSUM and ERR; hold_rst=0 in IDLE and DONE.
REQ-031 busy=1 in LEN0 through CSUM.
REQ-032 Timeout: in LEN0 through CSUM, TIMEOUT_CYC consecutive cycles with no accepted byte -> ERR. The counter restarts on every accepted byte.
REQ-033 Memory mux: while hold_rst=0, mem_a=vb_rom_a and mem_we=0. While hold_rst=1, mem_a is the write pointer.
REQ-034 mem_we is never asserted outside the write cycle defined in REQ-025.
REQ-035 A SYNC_BYTE received inside a frame is treated as data or length, never as a restart.
REQ-036 The pointer width is ADDR_W+1, so it cannot wrap inside a legal frame.

Reset
REQ-037 vb_rst asynchronously forces: state IDLE; rx_rdy_clr, mem_we, hold_rst, busy, done and err all 0; byte_cnt, pointer, checksum and timeout counter all 0.
REQ-038 vb_rst asserted mid-frame aborts the load; after release the block is in IDLE with err=0 and hold_rst=0.

Structure
REQ-039 Package uart_rom_loader_pkg holds the state enum, the default SYNC_BYTE and the default TIMEOUT_CYC.
REQ-040 The timeout counter is a sub-module named loader_timeout, with inputs clk, rst, run and kick and output expired.

Verification
REQ-041 Normal frame: A5 00 00 03 11 22 33 66 -> writes 11@0, 22@1, 33@2; done=1; err=0; byte_cnt=3; hold_rst falls one cycle after the checksum byte is accepted.
REQ-042 Bad checksum: A5 00 00 01 10 11 -> err=1 and hold_rst stays 1; a following good frame clears err and sets done.
REQ-043 Length errors: A5 00 00 00 -> ERR; A5 04 00 01 -> ERR; neither case produces any mem_we pulse.
REQ-044 Timeout: A5 00 00 02 01, then silence for TIMEOUT_CYC cycles -> err=1 exactly TIMEOUT_CYC cycles after the last acceptance; byte_cnt=1.
REQ-045 Handshake and mux: a garbage byte 3C in IDLE is consumed with one rx_rdy_clr pulse and causes no state change; in IDLE, mem_a tracks vb_rom_a=0x1234.
REQ-046 vb_rst pulsed after 2 payload bytes -> all outputs 0 and state IDLE; a new full frame then loads correctly.

Source files
------------

// File: rtl/uart_rom_loader_pkg.sv
// Shared types and defaults for the UART ROM loader: FSM state encoding, frame marker, timeout.
// Pure declarations, no logic, no clocking.
package uart_rom_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_LEN2,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [7:0] SYNC_BYTE_DEF   = 8'hA5;
    localparam int         TIMEOUT_CYC_DEF = 4000000;

    // A frame must carry at least one byte and must fit in the 2^addr_w byte image.
    function automatic logic len_ok(input logic [23:0] len, input int addr_w);
        return (len != 24'd0) && (64'(len) <= (64'd1 << addr_w));
    endfunction

endpackage

// File: rtl/loader_timeout.sv
// Inter-byte watchdog: expired is high in the last of TIMEOUT_CYC-1 idle cycles after a kick, so the
// owner's registered reaction lands exactly TIMEOUT_CYC cycles after the kick; no backpressure.
module loader_timeout #(
    parameter int TIMEOUT_CYC = 4000000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic kick,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt;

    // cnt is the index of the current idle cycle since the last kick (first idle cycle = 1).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!run || kick) begin
            cnt <= CW'(1);
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expired = run && !kick && (cnt == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/uart_rom_loader.sv
// Loads a sync/length/payload/checksum frame from a UART into ROM RAM, one write the cycle after each
// payload byte; bytes are consumed with a same-cycle rx_rdy_clr pulse, never two cycles in a row.
module uart_rom_loader
    import uart_rom_loader_pkg::*;
#(
    parameter int         ADDR_W      = 18,
    parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
    parameter int         TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              clk_4,
    input  logic              vb_rst,
    input  logic              rx_rdy,
    input  logic [7:0]        rx_data,
    output logic              rx_rdy_clr,
    input  logic [ADDR_W-1:0] vb_rom_a,
    output logic [ADDR_W-1:0] mem_a,
    output logic [7:0]        mem_d,
    output logic              mem_we,
    output logic              hold_rst,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   byte_cnt
);

    state_t          state;
    logic            clr_q;
    logic            acc;
    logic [15:0]     len_hi;
    logic [23:0]     remain;
    logic [7:0]      csum;
    logic [ADDR_W:0] ptr;
    logic            expired;

    // The UART drops rx_rdy one cycle after the clear, so the cycle after a clear is skipped.
    assign acc        = rx_rdy && !clr_q && !vb_rst;
    assign rx_rdy_clr = acc;

    assign busy     = (state == S_LEN0) || (state == S_LEN1) || (state == S_LEN2) ||
                      (state == S_DATA) || (state == S_CSUM);
    assign hold_rst = busy || (state == S_ERR);
    assign mem_a    = hold_rst ? ptr[ADDR_W-1:0] : vb_rom_a;

    loader_timeout #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk    (clk_4),
        .rst    (vb_rst),
        .run    (busy),
        .kick   (acc),
        .expired(expired)
    );

    always_ff @(posedge clk_4 or posedge vb_rst) begin
        if (vb_rst) begin
            state    <= S_IDLE;
            clr_q    <= 1'b0;
            len_hi   <= '0;
            remain   <= '0;
            csum     <= '0;
            ptr      <= '0;
            byte_cnt <= '0;
            mem_we   <= 1'b0;
            mem_d    <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            clr_q  <= acc;
            mem_we <= 1'b0;
            if (mem_we) begin
                ptr      <= ptr + (ADDR_W+1)'(1);
                byte_cnt <= byte_cnt + (ADDR_W+1)'(1);
            end
            if (expired) begin
                state <= S_ERR;
                err   <= 1'b1;
            end else begin
                case (state)
                    S_IDLE, S_ERR: begin
                        if (acc && rx_data == SYNC_BYTE) begin
                            state    <= S_LEN0;
                            done     <= 1'b0;
                            err      <= 1'b0;
                            byte_cnt <= '0;
                            csum     <= '0;
                            ptr      <= '0;
                        end
                    end
                    S_LEN0: if (acc) begin
                        len_hi[15:8] <= rx_data;
                        state        <= S_LEN1;
                    end
                    S_LEN1: if (acc) begin
                        len_hi[7:0] <= rx_data;
                        state       <= S_LEN2;
                    end
                    S_LEN2: if (acc) begin
                        remain <= {len_hi, rx_data};
                        if (len_ok({len_hi, rx_data}, ADDR_W)) begin
                            state <= S_DATA;
                        end else begin
                            state <= S_ERR;
                            err   <= 1'b1;
                        end
                    end
                    S_DATA: if (acc) begin
                        mem_we <= 1'b1;
                        mem_d  <= rx_data;
                        csum   <= csum + rx_data;
                        remain <= remain - 24'd1;
                        if (remain == 24'd1) begin
                            state <= S_CSUM;
                        end
                    end
                    S_CSUM: if (acc) begin
                        if (rx_data == csum) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_ERR;
                            err   <= 1'b1;
                        end
                    end
                    S_DONE:  state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rom_loader.sv
// Bench for uart_rom_loader: directed frames plus random frames scored against a frame-level model.
module tb_uart_rom_loader;

    localparam int AW = 18;
    localparam int TO = 40;

    logic          clk_4 = 1'b0;
    logic          vb_rst = 1'b1;
    logic          rx_rdy = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_rdy_clr;
    logic [AW-1:0] vb_rom_a = '0;
    logic [AW-1:0] mem_a;
    logic [7:0]    mem_d;
    logic          mem_we;
    logic          hold_rst;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW:0]   byte_cnt;

    uart_rom_loader #(
        .ADDR_W     (AW),
        .SYNC_BYTE  (8'hA5),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk_4     (clk_4),
        .vb_rst    (vb_rst),
        .rx_rdy    (rx_rdy),
        .rx_data   (rx_data),
        .rx_rdy_clr(rx_rdy_clr),
        .vb_rom_a  (vb_rom_a),
        .mem_a     (mem_a),
        .mem_d     (mem_d),
        .mem_we    (mem_we),
        .hold_rst  (hold_rst),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .byte_cnt  (byte_cnt)
    );

    always #5 clk_4 = ~clk_4;

    int            n_chk = 0;
    int            n_pass = 0;
    int            clr_pulses = 0;
    logic          clr_prev = 1'b0;
    logic          hold_at_acc = 1'b0;
    logic [AW-1:0] exp_wa[$];
    logic [7:0]    exp_wd[$];

    typedef struct packed {
        logic        err;
        logic        done;
        logic [31:0] cnt;
    } res_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Frame-level outcome: f starts with the sync byte; a short frame means the line went silent.
    function automatic res_t model(input logic [7:0] f[$]);
        res_t       r;
        int         len;
        logic [7:0] s;
        r.err  = 1'b1;
        r.done = 1'b0;
        r.cnt  = 0;
        if (f.size() < 4) return r;
        len = int'({f[1], f[2], f[3]});
        if (len == 0 || len > (1 << AW)) return r;
        r.cnt = (f.size() - 4 < len) ? f.size() - 4 : len;
        if (f.size() < len + 5) return r;
        s = 8'h00;
        for (int i = 0; i < len; i++) s += f[4+i];
        if (f[4+len] == s) begin
            r.err  = 1'b0;
            r.done = 1'b1;
        end
        return r;
    endfunction

    always @(negedge clk_4) begin
        if (vb_rst) begin
            clr_prev <= 1'b0;
        end else begin
            if (rx_rdy_clr) begin
                clr_pulses++;
                chk("clr_not_back_to_back", 32'(clr_prev), 32'd0);
            end
            clr_prev <= rx_rdy_clr;
            if (mem_we) begin
                chk("write_expected", 32'(exp_wa.size() != 0), 32'd1);
                if (exp_wa.size() != 0) begin
                    chk("write_addr", 32'(mem_a), 32'(exp_wa.pop_front()));
                    chk("write_data", 32'(mem_d), 32'(exp_wd.pop_front()));
                end
            end
            if (!hold_rst) begin
                chk("mux_addr", 32'(mem_a), 32'(vb_rom_a));
                chk("no_we_when_released", 32'(mem_we), 32'd0);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit got;
        got = 1'b0;
        repeat (gap) @(posedge clk_4);
        #1;
        rx_data = b;
        rx_rdy  = 1'b1;
        for (int k = 0; k < 8 && !got; k++) begin
            @(negedge clk_4);
            if (rx_rdy_clr) begin
                got         = 1'b1;
                hold_at_acc = hold_rst;
            end
        end
        chk("byte_accepted", 32'(got), 32'd1);
        @(posedge clk_4);
        #1;
        rx_rdy  = 1'b0;
        rx_data = 8'h00;
    endtask

    task automatic send_all(input logic [7:0] f[$], input int maxgap);
        foreach (f[i]) send_byte(f[i], int'($urandom_range(0, maxgap)));
    endtask

    task automatic do_frame(input logic [7:0] f[$], input int maxgap);
        res_t r;
        r = model(f);
        for (int i = 0; i < int'(r.cnt); i++) begin
            exp_wa.push_back(AW'(i));
            exp_wd.push_back(f[4+i]);
        end
        send_all(f, maxgap);
        repeat (TO + 4) @(posedge clk_4);
        #1;
        chk("frame_done", 32'(done), 32'(r.done));
        chk("frame_err", 32'(err), 32'(r.err));
        chk("frame_byte_cnt", 32'(byte_cnt), r.cnt);
        chk("frame_hold_rst", 32'(hold_rst), 32'(r.err));
        chk("frame_busy", 32'(busy), 32'd0);
        chk("frame_writes_drained", 32'(exp_wa.size()), 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        logic [7:0] f[$];
        res_t       r;
        int         len;
        int         kind;
        int         keep;
        int         c0;
        logic [7:0] s;
        logic [7:0] g;

        #12;
        chk("rst_rx_rdy_clr", 32'(rx_rdy_clr), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_hold_rst", 32'(hold_rst), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_byte_cnt", 32'(byte_cnt), 0);
        @(negedge clk_4);
        vb_rst = 1'b0;
        repeat (2) @(posedge clk_4);
        #1;

        // Normal frame with literal expectations.
        f = '{8'hA5, 8'h00, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
        r = model(f);
        chk("model_pin_good_done", 32'(r.done), 1);
        chk("model_pin_good_cnt", r.cnt, 3);
        exp_wa.push_back(AW'(0)); exp_wd.push_back(8'h11);
        exp_wa.push_back(AW'(1)); exp_wd.push_back(8'h22);
        exp_wa.push_back(AW'(2)); exp_wd.push_back(8'h33);
        send_all(f, 2);
        chk("good_hold_at_csum_accept", 32'(hold_at_acc), 1);
        chk("good_hold_falls_next_cycle", 32'(hold_rst), 0);
        repeat (2) @(posedge clk_4);
        #1;
        chk("good_done", 32'(done), 1);
        chk("good_err", 32'(err), 0);
        chk("good_byte_cnt", 32'(byte_cnt), 3);
        chk("good_writes_drained", 32'(exp_wa.size()), 0);

        // Bad checksum, then a good frame recovers.
        f = '{8'hA5, 8'h00, 8'h00, 8'h01, 8'h10, 8'h11};
        r = model(f);
        chk("model_pin_badcsum_err", 32'(r.err), 1);
        do_frame(f, 1);
        f = '{8'hA5, 8'h00, 8'h00, 8'h02, 8'hAA, 8'h55, 8'hFF};
        do_frame(f, 1);
        chk("recover_done", 32'(done), 1);

        // Length errors, including one byte past the image size.
        f = '{8'hA5, 8'h00, 8'h00, 8'h00};
        do_frame(f, 0);
        f = '{8'hA5, 8'h04, 8'h00, 8'h01};
        r = model(f);
        chk("model_pin_len_big_err", 32'(r.err), 1);
        do_frame(f, 0);

        // Timeout lands exactly TO cycles after the last accepted byte.
        f = '{8'hA5, 8'h00, 8'h00, 8'h02, 8'h01};
        exp_wa.push_back(AW'(0)); exp_wd.push_back(8'h01);
        send_all(f, 0);
        repeat (TO - 2) @(posedge clk_4);
        #1;
        chk("timeout_not_early", 32'(err), 0);
        @(posedge clk_4);
        #1;
        chk("timeout_on_time", 32'(err), 1);
        chk("timeout_byte_cnt", 32'(byte_cnt), 1);
        chk("timeout_hold", 32'(hold_rst), 1);

        // Garbage in IDLE after a good frame.
        f = '{8'hA5, 8'h00, 8'h00, 8'h01, 8'h7E, 8'h7E};
        do_frame(f, 1);
        vb_rom_a = AW'(18'h1234);
        #1;
        chk("idle_mux_1234", 32'(mem_a), 32'h1234);
        c0 = clr_pulses;
        send_byte(8'h3C, 0);
        repeat (3) @(posedge clk_4);
        #1;
        chk("garbage_one_clr", 32'(clr_pulses - c0), 1);
        chk("garbage_busy", 32'(busy), 0);
        chk("garbage_hold", 32'(hold_rst), 0);
        chk("garbage_done_kept", 32'(done), 1);

        // Reset mid-frame after two payload bytes.
        f = '{8'hA5, 8'h00, 8'h00, 8'h04, 8'h5A, 8'hC3};
        exp_wa.push_back(AW'(0)); exp_wd.push_back(8'h5A);
        exp_wa.push_back(AW'(1)); exp_wd.push_back(8'hC3);
        send_all(f, 1);
        repeat (3) @(posedge clk_4);
        #1;
        chk("midreset_writes_done", 32'(exp_wa.size()), 0);
        vb_rst = 1'b1;
        #2;
        chk("midreset_hold", 32'(hold_rst), 0);
        chk("midreset_busy", 32'(busy), 0);
        chk("midreset_err", 32'(err), 0);
        chk("midreset_done", 32'(done), 0);
        chk("midreset_we", 32'(mem_we), 0);
        chk("midreset_cnt", 32'(byte_cnt), 0);
        chk("midreset_mux", 32'(mem_a), 32'(vb_rom_a));
        @(posedge clk_4);
        #1;
        vb_rst = 1'b0;
        repeat (2) @(posedge clk_4);
        #1;
        chk("postreset_hold", 32'(hold_rst), 0);
        chk("postreset_err", 32'(err), 0);
        f = '{8'hA5, 8'h00, 8'h00, 8'h03, 8'h01, 8'hA5, 8'h02, 8'hA8};
        do_frame(f, 2);

        // Random frames: good, bad checksum, zero length, oversize length, truncated.
        for (int n = 0; n < 30; n++) begin
            kind     = int'($urandom_range(0, 4));
            len      = int'($urandom_range(1, 10));
            vb_rom_a = AW'($urandom);
            for (int gi = 0; gi < int'($urandom_range(0, 2)); gi++) begin
                g = 8'($urandom);
                if (g == 8'hA5) g = 8'h3C;
                send_byte(g, int'($urandom_range(0, 2)));
            end
            if (kind == 2) len = 0;
            if (kind == 3) len = 262145 + int'($urandom_range(0, 16777215 - 262145));
            f.delete();
            f.push_back(8'hA5);
            f.push_back(8'(len >> 16));
            f.push_back(8'(len >> 8));
            f.push_back(8'(len));
            keep = (kind == 4) ? int'($urandom_range(0, len)) : len;
            s    = 8'h00;
            if (kind <= 1 || kind == 4) begin
                for (int i = 0; i < keep; i++) begin
                    g = 8'($urandom);
                    s += g;
                    f.push_back(g);
                end
            end
            if (kind == 0) f.push_back(s);
            if (kind == 1) f.push_back(s + 8'($urandom_range(1, 255)));
            do_frame(f, 3);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
